// File: rtl/fwd_sel_reg_if.sv
// Bundle of the select/data inputs and registered outputs of fwd_sel_reg.
// clk and reset stay outside the bundle as plain ports.
interface fwd_sel_reg_if #(
    parameter int WIDTH = 32,
    parameter int NIN   = 3,
    parameter int SELW  = 2
);
    logic                  stall;
    logic                  flush;
    logic                  in_valid;
    logic [SELW-1:0]       sel;
    logic [NIN*WIDTH-1:0]  in_bus;
    logic                  err_clr;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  sel_err;

    // Producer side: drives select, data and control, observes the outputs.
    modport master (
        output stall, flush, in_valid, sel, in_bus, err_clr,
        input  out_data, out_valid, sel_err
    );

    // Register side: the fwd_sel_reg instance itself.
    modport slave (
        input  stall, flush, in_valid, sel, in_bus, err_clr,
        output out_data, out_valid, sel_err
    );
endinterface

// File: rtl/fwd_sel_reg.sv
// Forwarding select register: picks zero or one of NIN data slices and
// carries it through DEPTH pipeline stages with stall and flush control.
// An out-of-range select is forwarded as zero and latched in a sticky flag.
module fwd_sel_reg #(
    parameter int WIDTH = 32,
    parameter int NIN   = 3,
    parameter int SELW  = 2,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         reset,
    fwd_sel_reg_if.slave bus
);
    // Reject configurations the select encoding or pipeline cannot support.
    if (NIN < 1 || NIN > 15 || DEPTH < 1 || DEPTH > 4 || (1 << SELW) <= NIN) begin : g_bad_param
        $error("fwd_sel_reg: illegal NIN/SELW/DEPTH combination");
    end

    logic [WIDTH-1:0] sel_value;
    logic             sel_illegal;
    logic             advance;
    logic             err_set;
    logic             err_flag;
    logic [WIDTH-1:0] stg_data [DEPTH];
    logic [DEPTH-1:0] stg_valid;

    // Stage-0 mux: sel=0 and any code above NIN both yield zero.
    always_comb begin
        // NOTE: default first so every path assigns sel_value and no latch is inferred.
        sel_value = '0;
        for (int i = 0; i < NIN; i++) begin
            if (bus.sel == SELW'(i + 1)) begin
                sel_value = bus.in_bus[i*WIDTH +: WIDTH];
            end
        end
    end

    // Extra leading bit keeps the compare unsigned and wide enough for NIN.
    assign sel_illegal = {1'b0, bus.sel} > (SELW + 1)'(NIN);
    assign advance     = !bus.stall && !bus.flush;
    assign err_set     = bus.in_valid && advance && sel_illegal;

    // Pipeline: reset and flush clear every stage, stall holds, otherwise shift.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            stg_valid <= '0;
            // NOTE: the data array is cleared too, not just the valid bits, so a bubble always reads as zero.
            for (int n = 0; n < DEPTH; n++) begin
                stg_data[n] <= '0;
            end
        end else if (!bus.stall) begin
            // NOTE: non-blocking so each stage takes its predecessor's pre-edge value.
            stg_valid[0] <= bus.in_valid;
            stg_data[0]  <= bus.in_valid ? sel_value : '0;
            for (int n = 1; n < DEPTH; n++) begin
                stg_valid[n] <= stg_valid[n-1];
                stg_data[n]  <= stg_data[n-1];
            end
        end
    end

    // Sticky illegal-select flag; a new error beats a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_flag <= 1'b0;
        end else if (err_set) begin
            err_flag <= 1'b1;
        end else if (bus.err_clr) begin
            err_flag <= 1'b0;
        end
    end

    // Outputs come straight from the final stage flops.
    assign bus.out_data  = stg_data[DEPTH-1];
    assign bus.out_valid = stg_valid[DEPTH-1];
    assign bus.sel_err   = err_flag;
endmodule

// File: tb/tb_fwd_sel_reg.sv
// Bench for fwd_sel_reg: five instances with different NIN/SELW/DEPTH share
// one stimulus set; a single phase enables the monitor of one instance, and
// the stimulus pushes hand-computed expected outputs into a scoreboard queue.
module tb_fwd_sel_reg;
    localparam logic [31:0] S1 = 32'hAAAA0001;
    localparam logic [31:0] S2 = 32'hBBBB0002;
    localparam logic [31:0] S3 = 32'hCCCC0003;
    localparam logic [31:0] S4 = 32'hDDDD0004;
    localparam logic [31:0] S5 = 32'hEEEE0005;

    logic         clk = 1'b0;
    logic         reset;
    logic         stall, flush, in_valid, err_clr;
    logic [2:0]   sel3;
    logic [159:0] bus5;

    logic [4:0]   en;
    logic [4:0]   ov, se;
    logic [31:0]  od [5];
    logic         held;
    logic         last_v;
    logic [31:0]  last_d;
    logic [31:0]  exp_q [$];
    int           total = 0;
    int           bad   = 0;

    always #5 clk = ~clk;

    fwd_sel_reg_if #(.WIDTH(32), .NIN(3), .SELW(2)) if0 ();
    fwd_sel_reg_if #(.WIDTH(32), .NIN(3), .SELW(2)) if1 ();
    fwd_sel_reg_if #(.WIDTH(32), .NIN(3), .SELW(2)) if2 ();
    fwd_sel_reg_if #(.WIDTH(32), .NIN(5), .SELW(3)) if3 ();
    fwd_sel_reg_if #(.WIDTH(32), .NIN(5), .SELW(3)) if4 ();

    assign if0.stall = stall;  assign if0.flush = flush;  assign if0.in_valid = in_valid;
    assign if0.err_clr = err_clr;  assign if0.sel = sel3[1:0];  assign if0.in_bus = bus5[95:0];
    assign if1.stall = stall;  assign if1.flush = flush;  assign if1.in_valid = in_valid;
    assign if1.err_clr = err_clr;  assign if1.sel = sel3[1:0];  assign if1.in_bus = bus5[95:0];
    assign if2.stall = stall;  assign if2.flush = flush;  assign if2.in_valid = in_valid;
    assign if2.err_clr = err_clr;  assign if2.sel = sel3[1:0];  assign if2.in_bus = bus5[95:0];
    assign if3.stall = stall;  assign if3.flush = flush;  assign if3.in_valid = in_valid;
    assign if3.err_clr = err_clr;  assign if3.sel = sel3;  assign if3.in_bus = bus5;
    assign if4.stall = stall;  assign if4.flush = flush;  assign if4.in_valid = in_valid;
    assign if4.err_clr = err_clr;  assign if4.sel = sel3;  assign if4.in_bus = bus5;

    assign ov = {if4.out_valid, if3.out_valid, if2.out_valid, if1.out_valid, if0.out_valid};
    assign se = {if4.sel_err, if3.sel_err, if2.sel_err, if1.sel_err, if0.sel_err};
    assign od[0] = if0.out_data;
    assign od[1] = if1.out_data;
    assign od[2] = if2.out_data;
    assign od[3] = if3.out_data;
    assign od[4] = if4.out_data;

    fwd_sel_reg #(.WIDTH(32), .NIN(3), .SELW(2), .DEPTH(1)) u0 (.clk(clk), .reset(reset), .bus(if0));
    fwd_sel_reg #(.WIDTH(32), .NIN(3), .SELW(2), .DEPTH(2)) u1 (.clk(clk), .reset(reset), .bus(if1));
    fwd_sel_reg #(.WIDTH(32), .NIN(3), .SELW(2), .DEPTH(3)) u2 (.clk(clk), .reset(reset), .bus(if2));
    fwd_sel_reg #(.WIDTH(32), .NIN(5), .SELW(3), .DEPTH(1)) u3 (.clk(clk), .reset(reset), .bus(if3));
    fwd_sel_reg #(.WIDTH(32), .NIN(5), .SELW(3), .DEPTH(4)) u4 (.clk(clk), .reset(reset), .bus(if4));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Apply one cycle of inputs and return at the following negedge.
    task automatic step(input logic v, input logic [2:0] s, input logic st = 1'b0,
                        input logic fl = 1'b0, input logic ec = 1'b0);
        in_valid = v;
        sel3     = s;
        stall    = st;
        flush    = fl;
        err_clr  = ec;
        @(negedge clk);
    endtask

    // Reset every instance, then hand the monitor to instance k.
    task automatic phase(input int k);
        en       = '0;
        reset    = 1'b1;
        in_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        err_clr  = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
        en[k]    = 1'b1;
    endtask

    // An edge taken under stall (and no flush/reset) must leave outputs unchanged.
    always @(posedge clk) held <= stall && !flush && !reset;

    // Monitor: every fresh valid output pops the scoreboard; bubbles must read zero.
    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (en[k]) begin
                if (held) begin
                    check($sformatf("hold%0d valid", k), 32'(ov[k]), 32'(last_v));
                    check($sformatf("hold%0d data", k), od[k], last_d);
                end else if (ov[k]) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("unexpected valid u%0d", k), 32'(ov[k]), 32'd0);
                    end else begin
                        check($sformatf("data u%0d", k), od[k], exp_q.pop_front());
                    end
                    last_v = 1'b1;
                    last_d = od[k];
                end else begin
                    check($sformatf("bubble u%0d", k), od[k], 32'd0);
                    last_v = 1'b0;
                    last_d = '0;
                end
            end
        end
    end

    initial begin
        en       = '0;
        last_v   = 1'b0;
        last_d   = '0;
        reset    = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        sel3     = 3'd0;
        bus5     = {S5, S4, S3, S2, S1};
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("reset valid u%0d", k), 32'(ov[k]), 32'd0);
            check($sformatf("reset data u%0d", k), od[k], 32'd0);
            check($sformatf("reset err u%0d", k), 32'(se[k]), 32'd0);
        end

        // Basic select, DEPTH=1: one-cycle latency, sel=0 gives zero data.
        phase(0);
        exp_q.push_back(S1);    step(1'b1, 3'd1); check("basic v1", 32'(ov[0]), 32'd1);
        exp_q.push_back(S2);    step(1'b1, 3'd2); check("basic v2", 32'(ov[0]), 32'd1);
        exp_q.push_back(S3);    step(1'b1, 3'd3); check("basic v3", 32'(ov[0]), 32'd1);
        exp_q.push_back(32'd0); step(1'b1, 3'd0); check("basic v0", 32'(ov[0]), 32'd1);
        step(1'b0, 3'd0);       check("basic idle", 32'(ov[0]), 32'd0);
        check("basic drain", 32'(exp_q.size()), 32'd0);

        // Latency, DEPTH=3: valid only on the third edge.
        phase(2);
        exp_q.push_back(S2);
        step(1'b1, 3'd2); check("lat e1", 32'(ov[2]), 32'd0);
        step(1'b0, 3'd0); check("lat e2", 32'(ov[2]), 32'd0);
        step(1'b0, 3'd0); check("lat e3", 32'(ov[2]), 32'd1);
        step(1'b0, 3'd0); check("lat e4", 32'(ov[2]), 32'd0);
        check("lat drain", 32'(exp_q.size()), 32'd0);

        // Stall, DEPTH=2: output freezes for two cycles, order kept.
        phase(1);
        exp_q.push_back(S1); step(1'b1, 3'd1);
        exp_q.push_back(S2); step(1'b1, 3'd2);
        step(1'b1, 3'd3, 1'b1); check("stall hold1", 32'(ov[1]), 32'd1);
        step(1'b1, 3'd3, 1'b1); check("stall hold2", od[1], S1);
        exp_q.push_back(S3); step(1'b1, 3'd3);
        step(1'b0, 3'd0);
        step(1'b0, 3'd0);
        check("stall drain", 32'(exp_q.size()), 32'd0);

        // Flush with stall, DEPTH=2: S2 in flight is discarded, stream resumes.
        exp_q.push_back(S1); step(1'b1, 3'd1);
        step(1'b1, 3'd2);
        step(1'b1, 3'd3, 1'b1, 1'b1);
        check("flush valid", 32'(ov[1]), 32'd0);
        check("flush data", od[1], 32'd0);
        exp_q.push_back(S3); step(1'b1, 3'd3);
        step(1'b0, 3'd0); check("resume valid", 32'(ov[1]), 32'd1);
        step(1'b0, 3'd0);
        check("flush drain", 32'(exp_q.size()), 32'd0);

        // Illegal select, NIN=5 SELW=3: zero data, sticky flag, set beats clear.
        phase(3);
        exp_q.push_back(32'd0); step(1'b1, 3'd7);
        check("ill valid", 32'(ov[3]), 32'd1);
        check("ill data", od[3], 32'd0);
        check("ill err set", 32'(se[3]), 32'd1);
        exp_q.push_back(32'd0); step(1'b1, 3'd7, 1'b0, 1'b0, 1'b1);
        check("ill set wins", 32'(se[3]), 32'd1);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        check("ill err clr", 32'(se[3]), 32'd0);
        exp_q.push_back(S5); step(1'b1, 3'd5);
        check("legal sel5 err", 32'(se[3]), 32'd0);
        step(1'b1, 3'd7, 1'b1);
        check("stall no err", 32'(se[3]), 32'd0);
        step(1'b0, 3'd6);
        check("invalid no err", 32'(se[3]), 32'd0);
        check("ill drain", 32'(exp_q.size()), 32'd0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("default no err u%0d", k), 32'(se[k]), 32'd0);
        end

        // Reset mid-stream, DEPTH=4: pipe full, flag set, reset wins over all.
        phase(4);
        exp_q.push_back(S5); step(1'b1, 3'd5);
        step(1'b1, 3'd7);
        step(1'b1, 3'd4);
        step(1'b1, 3'd1);
        check("pre-reset err", 32'(se[4]), 32'd1);
        check("pre-reset valid", 32'(ov[4]), 32'd1);
        reset    = 1'b1;
        in_valid = 1'b1;
        sel3     = 3'd7;
        @(negedge clk);
        reset    = 1'b0;
        check("rst valid", 32'(ov[4]), 32'd0);
        check("rst data", od[4], 32'd0);
        check("rst err", 32'(se[4]), 32'd0);
        exp_q.push_back(S3);
        step(1'b1, 3'd3); check("post-rst e1", 32'(ov[4]), 32'd0);
        step(1'b0, 3'd0); check("post-rst e2", 32'(ov[4]), 32'd0);
        step(1'b0, 3'd0); check("post-rst e3", 32'(ov[4]), 32'd0);
        step(1'b0, 3'd0); check("post-rst e4", 32'(ov[4]), 32'd1);
        step(1'b0, 3'd0); check("post-rst e5", 32'(ov[4]), 32'd0);
        check("rst drain", 32'(exp_q.size()), 32'd0);

        en = '0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
